fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter that shares one FIFO write port (data_in/wr_en/full) among NREQ producers.

---
 rtl/fifo_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// Each grant lasts up to BURST accepted beats; the port never writes while
// the FIFO reports full.
// Optional: define FIFO_ARB_STATS_EN to add the 16-bit beat_total counter.
//
// state | meaning
// IDLE  | no grant held; round-robin search picks the next grantee
// BUSY  | grant_id owns the FIFO write port until burst end or valid drop
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int IDW   = 2,
   parameter int BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [DW-1:0]        fifo_data_in,
   output logic [IDW-1:0]       grant_id,
`ifdef FIFO_ARB_STATS_EN
   output logic [15:0]          beat_total,
`endif
   output logic                 busy
);

   // Index space padded to 2**IDW so every grant index selects exactly.
   localparam int NSLOT = 1 << IDW;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  grant_q, grant_d;
   logic [IDW-1:0]  last_q, last_d;
   logic [7:0]      beat_cnt_q, beat_cnt_d;

   logic [NSLOT-1:0] valid_pad;
   logic [DW-1:0]    data_slot [NSLOT];
   logic             arb_found;
   logic [IDW-1:0]   arb_idx;
   logic [IDW:0]     cand_sum;
   logic [IDW-1:0]   cand;
   logic             beat;

   assign valid_pad = NSLOT'(req_valid);

   // Unpack the flat request data bus into per-requester words.
   always_comb begin
      for (int s = 0; s < NSLOT; s++) begin
         data_slot[s] = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
         data_slot[i] = req_data[i*DW +: DW];
      end
   end

   // Round-robin search starting one past the last grantee, wrapping modulo NREQ.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_sum = {1'b0, last_q} + (IDW+1)'(k);
         if (cand_sum >= (IDW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NREQ);
         end
         cand = cand_sum[IDW-1:0];
         if (!arb_found && valid_pad[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   assign beat = (state_q == BUSY) && valid_pad[grant_q] && !fifo_full;

   // State, grant and burst-count registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_q     <= IDW'(NREQ-1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Next-state logic: a full FIFO simply holds grant and count, with no timeout.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d    = arb_idx;
               last_d     = arb_idx;
               beat_cnt_d = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (!valid_pad[grant_q]) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
            end else if (beat) begin
               if (beat_cnt_q == 8'(BURST-1)) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One-hot ready back to the grantee on each beat.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (beat && (grant_q == IDW'(i))) begin
            req_ready[i] = 1'b1;
         end
      end
   end

   assign fifo_wr_en   = beat;
   assign fifo_data_in = (state_q == BUSY) ? data_slot[grant_q] : '0;
   assign grant_id     = grant_q;
   assign busy         = (state_q == BUSY);

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] beat_total_q;

   // Free-running count of FIFO writes; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         beat_total_q <= '0;
      end else if (beat) begin
         beat_total_q <= beat_total_q + 16'd1;
      end
   end

   assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers push their words into a scoreboard as
// they present them; a negedge monitor runs a reference arbitration model
// and pops the scoreboard whenever the FIFO port writes.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int IDW   = 2;
   localparam int BURST = 4;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*DW-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_ready;
   logic                fifo_full = 1'b0;
   logic                fifo_wr_en;
   logic [DW-1:0]       fifo_data_in;
   logic [IDW-1:0]      grant_id;
   logic                busy;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0]         beat_total;
`endif

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .BURST(BURST)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .grant_id     (grant_id),
`ifdef FIFO_ARB_STATS_EN
      .beat_total   (beat_total),
`endif
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   typedef struct {
      int            id;
      logic [DW-1:0] d;
   } sb_t;

   sb_t sb[$];

   // Producer state.
   bit            have   [NREQ];
   int            budget [NREQ];
   int            pct    [NREQ];
   logic [DW-1:0] cur    [NREQ];
   logic [DW-1:0] nxt    [NREQ];
   bit            seq_mode = 1'b1;

   // Reference model state.
   bit            m_busy  = 1'b0;
   int            m_grant = 0;
   int            m_last  = NREQ-1;
   int            m_beats = 0;
   logic [15:0]   m_total = '0;
   int            grant_log[$];
   int            wr_count = 0;
   bit            mon_eb;
   logic [NREQ-1:0] mon_er;
   int            mon_idx;
   int            mon_g;

   function automatic int rr(int last, logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // Monitor: compare DUT outputs against the model, then advance the model.
   always @(negedge clk) begin
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_grant);
      mon_eb = m_busy && req_valid[m_grant] && !fifo_full;
      mon_er = mon_eb ? (NREQ'(1) << m_grant) : '0;
      chk("fifo_wr_en", fifo_wr_en, mon_eb);
      chk("req_ready", req_ready, mon_er);
      chk("fifo_data_in", fifo_data_in, m_busy ? req_data[m_grant*DW +: DW] : '0);
`ifdef FIFO_ARB_STATS_EN
      chk("beat_total", beat_total, m_total);
`endif
      if (mon_eb && reset_n) begin
         wr_count++;
         mon_idx = -1;
         for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].id == m_grant) begin
               mon_idx = k;
               break;
            end
         end
         if (mon_idx < 0) begin
            chk("sb_unexpected_write", fifo_data_in, 32'hFFFF_FFFF);
         end else begin
            chk("sb_data", fifo_data_in, sb[mon_idx].d);
            sb.delete(mon_idx);
         end
      end
      if (!reset_n) begin
         m_busy = 1'b0; m_grant = 0; m_last = NREQ-1; m_beats = 0; m_total = '0;
      end else begin
         if (mon_eb) m_total = m_total + 16'd1;
         if (!m_busy) begin
            mon_g = rr(m_last, req_valid);
            if (mon_g >= 0) begin
               m_busy = 1'b1; m_grant = mon_g; m_last = mon_g; m_beats = 0;
               grant_log.push_back(mon_g);
            end
         end else if (!req_valid[m_grant]) begin
            m_busy = 1'b0;
         end else if (mon_eb) begin
            m_beats++;
            if (m_beats == BURST) m_busy = 1'b0;
         end
      end
   end

   task automatic step();
      bit acc [NREQ];
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) acc[i] = reset_n && req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) have[i] = 1'b0;
         if (!have[i] && budget[i] > 0 && $urandom_range(99) < pct[i]) begin
            have[i] = 1'b1;
            budget[i]--;
            if (seq_mode) begin
               cur[i] = nxt[i];
               nxt[i] = nxt[i] + 1'b1;
            end else begin
               cur[i] = DW'($urandom);
            end
            sb.push_back('{id: i, d: cur[i]});
         end
         req_valid[i]         = have[i];
         req_data[i*DW +: DW] = cur[i];
      end
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   function automatic bit drained();
      for (int i = 0; i < NREQ; i++) if (budget[i] != 0 || have[i]) return 1'b0;
      return sb.size() == 0;
   endfunction

   task automatic drain();
      int n = 0;
      fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) pct[i] = 100;
      while (!drained() && n < 1000) begin
         step();
         n++;
      end
      chk("drain_done", drained(), 1);
   endtask

   task automatic do_reset();
      drain();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   function automatic int log_at(int i);
      return (grant_log.size() > i) ? grant_log[i] : -1;
   endfunction

   // Main stimulus sequence.
   initial begin
      int base;
      for (int i = 0; i < NREQ; i++) begin
         have[i] = 1'b0; budget[i] = 0; pct[i] = 100; cur[i] = '0;
         nxt[i] = DW'(8'h10 * (i + 1));
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single requester, six words across two bursts.
      grant_log.delete();
      base = wr_count;
      nxt[1] = 8'h35;
      budget[1] = 6;
      run(20);
      chk("t1_grant_count", grant_log.size(), 2);
      chk("t1_grant0", log_at(0), 1);
      chk("t1_grant1", log_at(1), 1);
      chk("t1_words", wr_count - base, 6);

      // Fair rotation with every requester busy.
      do_reset();
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) budget[i] = 2 * BURST;
      run(50);
      for (int i = 0; i < 5; i++) chk("t2_order", log_at(i), i % NREQ);

      // FIFO full stall in the middle of a burst.
      do_reset();
      base = wr_count;
      budget[0] = 4;
      run(4);
      fifo_full = 1'b1;
      run(3);
      fifo_full = 1'b0;
      run(10);
      chk("t3_words", wr_count - base, 4);
      chk("t3_sb_empty", sb.size(), 0);

      // Early release hands over to the next requester.
      do_reset();
      grant_log.delete();
      budget[2] = 2;
      budget[3] = 4;
      run(15);
      chk("t4_grant_count", grant_log.size(), 2);
      chk("t4_grant0", log_at(0), 2);
      chk("t4_grant1", log_at(1), 3);

      // Reset in the middle of a req-1 burst.
      do_reset();
      grant_log.delete();
      budget[0] = 1;
      budget[1] = 20;
      run(6);
      chk("t5_pre0", log_at(0), 0);
      chk("t5_pre1", log_at(1), 1);
      budget[0] = 5;
      grant_log.delete();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      run(3);
      chk("t5_after_reset", log_at(0), 0);
      drain();

      // Randomised traffic with FIFO back-pressure and occasional resets.
      seq_mode = 1'b0;
      for (int c = 0; c < 400; c++) begin
         fifo_full = ($urandom_range(99) < 25);
         for (int i = 0; i < NREQ; i++) begin
            if (budget[i] == 0 && $urandom_range(9) == 0) begin
               budget[i] = $urandom_range(6, 1);
               pct[i]    = $urandom_range(100, 30);
            end
         end
         reset_n = ($urandom_range(199) != 0);
         step();
      end
      reset_n = 1'b1;
      drain();
      chk("final_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
